mem_responder: RTL and testbench
================================

// Module: mem_responder
// PURPOSE
// Synthesizable memory-side responder for the tag cache memory port (MemReqCMD / MemData / MemResp).
// Accepts line write commands plus their data beats, and read commands answered with data beats after a fixed latency.
// Sits below TagCacheWrapper in test_top, replacing the tester's behavioural memory model so runs are cycle-deterministic.
// PARAMETERS
// ADDR_WIDTH   26   line (block) address width of mem_cmd_addr
// TAG_WIDTH    5    transaction tag width, returned unchanged on mem_resp_tag
// DATA_WIDTH   128  bits per data beat
// BEATS        4    data beats per cache line (power of 2, >=2)
// DEPTH_LOG2   10   log2 of lines stored; index = addr[DEPTH_LOG2-1:0], upper address bits alias
// RD_LATENCY   8    cycles from read-command accept to first resp beat (>=1)
// PORTS
// clk             in   1           clock
// reset           in   1           asynchronous, active-high reset
// mem_cmd_valid   in   1           command valid
// mem_cmd_ready   out  1           command accepted when valid&ready
// mem_cmd_addr    in   ADDR_WIDTH  line address
// mem_cmd_tag     in   TAG_WIDTH   transaction tag
// mem_cmd_rw      in   1           1 = write, 0 = read
// mem_data_valid  in   1           write data beat valid
// mem_data_ready  out  1           beat accepted when valid&ready
// mem_data_data   in   DATA_WIDTH  write data beat
// mem_resp_valid  out  1           read data beat valid
// mem_resp_ready  in   1           beat consumed when valid&ready
// mem_resp_data   out  DATA_WIDTH  read data beat
// mem_resp_tag    out  TAG_WIDTH   tag of the read being answered
// proto_err       out  1           sticky: data beat offered while not in WRITE
// BEHAVIOUR
// - Reset: state=IDLE; mem_cmd_ready=0 during reset, 1 in first IDLE cycle; mem_data_ready=0; mem_resp_valid=0;
//   mem_resp_data/tag=0; proto_err=0; beat and latency counters=0; per-line written bits cleared. Array not reset.
// - FSM IDLE: mem_cmd_ready=1. On cmd handshake latch addr index+tag; rw=1 -> WRITE, rw=0 -> RD_WAIT.
// - WRITE: mem_cmd_ready=0, mem_data_ready=1; each beat handshake writes array[idx][beat], beat++.
//   Last beat (beat==BEATS-1) sets written[idx], beat wraps to 0, -> IDLE. Writes produce no response.
// - RD_WAIT: latency counter counts RD_LATENCY-1 cycles down to 0 after accept, then -> RD_RESP; first beat
//   valid exactly RD_LATENCY cycles after the cmd handshake cycle.
// - RD_RESP: mem_resp_valid=1, data = written[idx] ? array[idx][beat] : 0, tag = latched tag.
//   Data/tag held stable while valid&!ready (no drop, no change). On handshake beat++; after beat BEATS-1 -> IDLE.
// - One transaction in flight; a command is never accepted while WRITE/RD_WAIT/RD_RESP (ready low).
// - Read-after-write to same line: write completes (IDLE reached) before the read is accepted, so read
//   returns the new data; no bypass needed.
// - proto_err: set when mem_data_valid=1 in any state other than WRITE; sticky until reset; beat not consumed.
// - Address aliasing: addresses differing only above DEPTH_LOG2 share storage (documented, not an error).
// - Reset asserted mid-transaction: returns to IDLE immediately, partial write keeps beats already written
//   but line stays unwritten (reads return 0); pending read is dropped with no response.
// - Beat counter width $clog2(BEATS); latency counter width $clog2(RD_LATENCY+1); both wrap-free by FSM.
// STRUCTURE
// - cache_pkg: mem_cmd_t {addr,tag,rw}, MEM_DATA_WIDTH, MEM_TAG_WIDTH, MEM_ADDR_WIDTH, MEM_BEATS,
//   and the responder state enum mem_rsp_state_e {IDLE, WRITE, RD_WAIT, RD_RESP}.
// - Sub-module mem_line_store: DEPTH*BEATS x DATA_WIDTH array, one write port, one combinational read port,
//   plus the reset-cleared written-bit vector. FSM, counters and handshakes stay in mem_responder.
// TESTING
// - Write addr 0x10 tag 3, beats A0..A3 (0x..A0..0x..A3) back-to-back -> 4 data handshakes, no resp, IDLE after.
// - Read addr 0x10 tag 7 -> resp_valid rises 8 cycles after accept; beats A0..A3 in order, tag 7 on all.
// - Read never-written addr 0x22 tag 1 -> 4 beats of 0, tag 1; same with addr 0x22+1024 after writing 0x22 -> alias data.
// - Read with mem_resp_ready toggled 1,0,0,1,... -> each beat held stable while stalled, exactly 4 handshakes.
// - Cmd offered during RD_WAIT and data beat offered in IDLE -> cmd_ready=0 until IDLE; proto_err=1 and sticky.
// - Reset asserted after 2 of 4 write beats, then read same addr -> 4 beats of 0; outputs at reset values during reset.

Source files
------------

// File: rtl/cache_pkg.sv
// cache_pkg
// Shared types and default sizes for the tag cache memory port.
// mem_cmd_t bundles one command (line address, transaction tag, read/write).
// mem_rsp_state_e lists the states of the memory-side responder.
package cache_pkg;

    localparam int MEM_ADDR_WIDTH  = 26;
    localparam int MEM_TAG_WIDTH   = 5;
    localparam int MEM_DATA_WIDTH  = 128;
    localparam int MEM_BEATS       = 4;
    localparam int MEM_DEPTH_LOG2  = 10;
    localparam int MEM_RD_LATENCY  = 8;

    typedef struct packed {
        logic [MEM_ADDR_WIDTH-1:0] addr;
        logic [MEM_TAG_WIDTH-1:0]  tag;
        logic                      rw;
    } mem_cmd_t;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        RD_WAIT,
        RD_RESP
    } mem_rsp_state_e;

endpackage

// File: rtl/mem_line_store.sv
// mem_line_store
// Line storage for mem_responder: DEPTH lines of BEATS data beats each,
// one synchronous write port and one combinational read port. A per-line
// written bit (cleared by reset) masks reads of lines that have never been
// fully written, so such lines read back as zero.
// Ports:
//   clk, reset      clock, asynchronous active-high reset (written bits only)
//   wr_en           write wr_data into line wr_idx, beat wr_beat
//   set_written     mark line wr_idx as fully written
//   rd_idx, rd_beat read address
//   rd_data         stored beat, or zero if the line is not marked written
module mem_line_store #(
    parameter int DATA_WIDTH = 128,
    parameter int BEATS      = 4,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          wr_en,
    input  logic                          set_written,
    input  logic [DEPTH_LOG2-1:0]         wr_idx,
    input  logic [$clog2(BEATS)-1:0]      wr_beat,
    input  logic [DATA_WIDTH-1:0]         wr_data,
    input  logic [DEPTH_LOG2-1:0]         rd_idx,
    input  logic [$clog2(BEATS)-1:0]      rd_beat,
    output logic [DATA_WIDTH-1:0]         rd_data
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [DATA_WIDTH-1:0] lines [DEPTH*BEATS];
    logic [DEPTH-1:0]      written;

    // The data array is deliberately not reset; beats written before a
    // reset survive, but the cleared written bit hides them.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            lines[{wr_idx, wr_beat}] <= wr_data;
        end
    end

    // A line only becomes readable once its final beat has been stored.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            written <= '0;
        end else if (set_written) begin
            written[wr_idx] <= 1'b1;
        end
    end

    assign rd_data = written[rd_idx] ? lines[{rd_idx, rd_beat}] : '0;

endmodule

// File: rtl/mem_responder.sv
// mem_responder
// Memory-side responder for the tag cache memory port. Accepts line write
// commands followed by BEATS data beats, and read commands answered with
// BEATS response beats starting RD_LATENCY cycles after the command is
// accepted. Only one transaction is in flight at a time.
// Ports:
//   clk, reset                       clock, asynchronous active-high reset
//   mem_cmd_valid/ready/addr/tag/rw  command channel (rw: 1 write, 0 read)
//   mem_data_valid/ready/data        write data beats
//   mem_resp_valid/ready/data/tag    read response beats
//   proto_err                        sticky: data beat offered outside WRITE
// Lines are indexed by the low DEPTH_LOG2 address bits; higher address bits
// alias onto the same storage.
module mem_responder
    import cache_pkg::*;
#(
    parameter int ADDR_WIDTH = MEM_ADDR_WIDTH,
    parameter int TAG_WIDTH  = MEM_TAG_WIDTH,
    parameter int DATA_WIDTH = MEM_DATA_WIDTH,
    parameter int BEATS      = MEM_BEATS,
    parameter int DEPTH_LOG2 = MEM_DEPTH_LOG2,
    parameter int RD_LATENCY = MEM_RD_LATENCY
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mem_cmd_valid,
    output logic                  mem_cmd_ready,
    input  logic [ADDR_WIDTH-1:0] mem_cmd_addr,
    input  logic [TAG_WIDTH-1:0]  mem_cmd_tag,
    input  logic                  mem_cmd_rw,
    input  logic                  mem_data_valid,
    output logic                  mem_data_ready,
    input  logic [DATA_WIDTH-1:0] mem_data_data,
    output logic                  mem_resp_valid,
    input  logic                  mem_resp_ready,
    output logic [DATA_WIDTH-1:0] mem_resp_data,
    output logic [TAG_WIDTH-1:0]  mem_resp_tag,
    output logic                  proto_err
);

    localparam int BEAT_W = $clog2(BEATS);
    localparam int LAT_W  = $clog2(RD_LATENCY + 1);

    mem_rsp_state_e        state;
    logic [DEPTH_LOG2-1:0] idx;
    logic [TAG_WIDTH-1:0]  tag_q;
    logic [BEAT_W-1:0]     beat;
    logic [LAT_W-1:0]      lat_cnt;

    logic                  cmd_hs;
    logic                  data_hs;
    logic                  resp_hs;
    logic                  last_beat;
    logic [BEAT_W-1:0]     rd_beat;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  unused_addr_hi;

    assign cmd_hs    = mem_cmd_valid & mem_cmd_ready;
    assign data_hs   = mem_data_valid & mem_data_ready;
    assign resp_hs   = mem_resp_valid & mem_resp_ready;
    assign last_beat = (beat == BEAT_W'(BEATS - 1));

    // Address bits above the line index alias and are intentionally ignored.
    assign unused_addr_hi = ^mem_cmd_addr[ADDR_WIDTH-1:DEPTH_LOG2];

    // The response data register is loaded one beat ahead: while waiting it
    // fetches beat 0, and on each response handshake it fetches the next beat.
    assign rd_beat = (state == RD_RESP) ? beat + BEAT_W'(1) : '0;

    mem_line_store #(
        .DATA_WIDTH (DATA_WIDTH),
        .BEATS      (BEATS),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_store (
        .clk         (clk),
        .reset       (reset),
        .wr_en       (data_hs),
        .set_written (data_hs & last_beat),
        .wr_idx      (idx),
        .wr_beat     (beat),
        .wr_data     (mem_data_data),
        .rd_idx      (idx),
        .rd_beat     (rd_beat),
        .rd_data     (rd_data)
    );

    // Transaction FSM with registered handshake outputs. The ready/valid
    // outputs are set on the same edge that enters the state using them, so
    // cmd_ready is high in every IDLE cycle after the first edge out of reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            idx            <= '0;
            tag_q          <= '0;
            beat           <= '0;
            lat_cnt        <= '0;
            mem_cmd_ready  <= 1'b0;
            mem_data_ready <= 1'b0;
            mem_resp_valid <= 1'b0;
            mem_resp_data  <= '0;
            mem_resp_tag   <= '0;
            proto_err      <= 1'b0;
        end else begin
            if (mem_data_valid && (state != WRITE)) begin
                proto_err <= 1'b1;
            end
            case (state)
                IDLE: begin
                    mem_cmd_ready <= 1'b1;
                    if (cmd_hs) begin
                        idx           <= mem_cmd_addr[DEPTH_LOG2-1:0];
                        tag_q         <= mem_cmd_tag;
                        beat          <= '0;
                        mem_cmd_ready <= 1'b0;
                        if (mem_cmd_rw) begin
                            state          <= WRITE;
                            mem_data_ready <= 1'b1;
                        end else begin
                            state   <= RD_WAIT;
                            lat_cnt <= LAT_W'(RD_LATENCY - 1);
                        end
                    end
                end
                WRITE: begin
                    if (data_hs) begin
                        if (last_beat) begin
                            beat           <= '0;
                            state          <= IDLE;
                            mem_data_ready <= 1'b0;
                            mem_cmd_ready  <= 1'b1;
                        end else begin
                            beat <= beat + BEAT_W'(1);
                        end
                    end
                end
                RD_WAIT: begin
                    if (lat_cnt == '0) begin
                        state          <= RD_RESP;
                        mem_resp_valid <= 1'b1;
                        mem_resp_data  <= rd_data;
                        mem_resp_tag   <= tag_q;
                    end else begin
                        lat_cnt <= lat_cnt - LAT_W'(1);
                    end
                end
                RD_RESP: begin
                    if (resp_hs) begin
                        if (last_beat) begin
                            beat           <= '0;
                            state          <= IDLE;
                            mem_resp_valid <= 1'b0;
                            mem_resp_data  <= '0;
                            mem_resp_tag   <= '0;
                            mem_cmd_ready  <= 1'b1;
                        end else begin
                            beat          <= beat + BEAT_W'(1);
                            mem_resp_data <= rd_data;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder
// Self-checking bench for mem_responder: a table of directed transactions,
// hand-written sequences for stalls, busy commands, protocol errors and
// reset mid-write, then randomized traffic checked against a line-level
// reference model held in associative arrays.
module tb_mem_responder;
    import cache_pkg::*;

    localparam int BEATS      = MEM_BEATS;
    localparam int DW         = MEM_DATA_WIDTH;
    localparam int RD_LATENCY = MEM_RD_LATENCY;
    localparam int NVEC       = 9;

    logic                      clk;
    logic                      reset;
    logic                      mem_cmd_valid;
    logic                      mem_cmd_ready;
    logic [MEM_ADDR_WIDTH-1:0] mem_cmd_addr;
    logic [MEM_TAG_WIDTH-1:0]  mem_cmd_tag;
    logic                      mem_cmd_rw;
    logic                      mem_data_valid;
    logic                      mem_data_ready;
    logic [DW-1:0]             mem_data_data;
    logic                      mem_resp_valid;
    logic                      mem_resp_ready;
    logic [DW-1:0]             mem_resp_data;
    logic [MEM_TAG_WIDTH-1:0]  mem_resp_tag;
    logic                      proto_err;

    mem_responder #(
        .ADDR_WIDTH (MEM_ADDR_WIDTH),
        .TAG_WIDTH  (MEM_TAG_WIDTH),
        .DATA_WIDTH (DW),
        .BEATS      (BEATS),
        .DEPTH_LOG2 (MEM_DEPTH_LOG2),
        .RD_LATENCY (RD_LATENCY)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .mem_cmd_valid  (mem_cmd_valid),
        .mem_cmd_ready  (mem_cmd_ready),
        .mem_cmd_addr   (mem_cmd_addr),
        .mem_cmd_tag    (mem_cmd_tag),
        .mem_cmd_rw     (mem_cmd_rw),
        .mem_data_valid (mem_data_valid),
        .mem_data_ready (mem_data_ready),
        .mem_data_data  (mem_data_data),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_ready (mem_resp_ready),
        .mem_resp_data  (mem_resp_data),
        .mem_resp_tag   (mem_resp_tag),
        .proto_err      (proto_err)
    );

    typedef struct {
        mem_cmd_t    cmd;
        logic [31:0] base;
        int          mode;
        logic        exp_zero;
        logic [31:0] exp_base;
    } vec_t;

    vec_t          vecs [NVEC];
    logic [DW-1:0] wbeats [BEATS];
    logic [DW-1:0] exp_beats [BEATS];

    logic [DW-1:0] model_mem [int];
    bit            model_written [int];

    int vec_cnt     = 0;
    int miscompares = 0;
    int data_hs_cnt = 0;
    int resp_hs_cnt = 0;

    // Free-running clock, 10 time units per cycle.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count data and response handshakes as the DUT sees them on each edge.
    always @(posedge clk) begin
        if (!reset) begin
            if (mem_data_valid && mem_data_ready) data_hs_cnt <= data_hs_cnt + 1;
            if (mem_resp_valid && mem_resp_ready) resp_hs_cnt <= resp_hs_cnt + 1;
        end
    end

    // Guard against a hung handshake somewhere in the sequences.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        vec_cnt++;
        if (act !== req) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, required %h at %0t", name, act, req, $time);
        end
    endtask

    function automatic vec_t mk(input logic rw, input logic [MEM_ADDR_WIDTH-1:0] addr,
                                input logic [MEM_TAG_WIDTH-1:0] tag, input logic [31:0] base,
                                input int mode, input logic exp_zero, input logic [31:0] exp_base);
        vec_t v;
        v.cmd.addr   = addr;
        v.cmd.tag    = tag;
        v.cmd.rw     = rw;
        v.base       = base;
        v.mode       = mode;
        v.exp_zero   = exp_zero;
        v.exp_base   = exp_base;
        return v;
    endfunction

    function automatic logic [DW-1:0] model_beat(input int line, input int b);
        if (model_written.exists(line)) return model_mem[line*BEATS + b];
        return '0;
    endfunction

    task automatic checkResetValues(input string where);
        checkOutput({where, "_cmd_ready"}, DW'(mem_cmd_ready), DW'(1'b0));
        checkOutput({where, "_data_ready"}, DW'(mem_data_ready), DW'(1'b0));
        checkOutput({where, "_resp_valid"}, DW'(mem_resp_valid), DW'(1'b0));
        checkOutput({where, "_resp_data"}, mem_resp_data, '0);
        checkOutput({where, "_resp_tag"}, DW'(mem_resp_tag), '0);
        checkOutput({where, "_proto_err"}, DW'(proto_err), DW'(1'b0));
    endtask

    task automatic send_cmd(input logic [MEM_ADDR_WIDTH-1:0] addr, input logic [MEM_TAG_WIDTH-1:0] tag,
                            input logic rw, input bit keep);
        int n;
        n = 0;
        mem_cmd_valid = 1'b1;
        mem_cmd_addr  = addr;
        mem_cmd_tag   = tag;
        mem_cmd_rw    = rw;
        while (!mem_cmd_ready && n < 50) begin
            tick();
            n++;
        end
        checkOutput("cmd_accept", DW'(mem_cmd_ready), DW'(1'b1));
        tick();
        if (!keep) mem_cmd_valid = 1'b0;
    endtask

    task automatic send_data(input int nbeats);
        int n;
        for (int b = 0; b < nbeats; b++) begin
            mem_data_valid = 1'b1;
            mem_data_data  = wbeats[b];
            n = 0;
            while (!mem_data_ready && n < 50) begin
                tick();
                n++;
            end
            checkOutput("data_ready", DW'(mem_data_ready), DW'(1'b1));
            tick();
        end
        mem_data_valid = 1'b0;
    endtask

    task automatic do_write(input logic [MEM_ADDR_WIDTH-1:0] addr, input logic [MEM_TAG_WIDTH-1:0] tag);
        int d0;
        int r0;
        int line;
        d0 = data_hs_cnt;
        r0 = resp_hs_cnt;
        send_cmd(addr, tag, 1'b1, 1'b0);
        send_data(BEATS);
        checkOutput("write_data_handshakes", DW'(data_hs_cnt - d0), DW'(BEATS));
        checkOutput("write_no_resp", DW'(resp_hs_cnt - r0), '0);
        checkOutput("write_back_to_idle", DW'(mem_cmd_ready), DW'(1'b1));
        line = int'(addr[MEM_DEPTH_LOG2-1:0]);
        for (int b = 0; b < BEATS; b++) model_mem[line*BEATS + b] = wbeats[b];
        model_written[line] = 1'b1;
    endtask

    // mode 0: always ready, mode 1: ready pattern 1,0,0,1 repeating, else random.
    task automatic collect_resp(input logic [MEM_TAG_WIDTH-1:0] tag, input int mode, input int elapsed);
        int   lat;
        int   beats;
        int   cyc;
        int   r0;
        logic rdy;
        lat   = 0;
        beats = 0;
        cyc   = 0;
        r0    = resp_hs_cnt;
        while (!mem_resp_valid && lat < 64) begin
            tick();
            lat++;
        end
        checkOutput("read_latency", DW'(lat + elapsed), DW'(RD_LATENCY));
        while (beats < BEATS && cyc < 64) begin
            if (mode == 0) rdy = 1'b1;
            else if (mode == 1) rdy = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            else rdy = 1'($urandom_range(0, 1));
            mem_resp_ready = rdy;
            checkOutput("resp_valid", DW'(mem_resp_valid), DW'(1'b1));
            checkOutput("resp_data", mem_resp_data, exp_beats[beats]);
            checkOutput("resp_tag", DW'(mem_resp_tag), DW'(tag));
            if (rdy) beats++;
            tick();
            cyc++;
        end
        mem_resp_ready = 1'b0;
        checkOutput("resp_handshakes", DW'(resp_hs_cnt - r0), DW'(BEATS));
        checkOutput("resp_valid_after_burst", DW'(mem_resp_valid), DW'(1'b0));
        checkOutput("cmd_ready_after_read", DW'(mem_cmd_ready), DW'(1'b1));
    endtask

    task automatic do_read(input logic [MEM_ADDR_WIDTH-1:0] addr, input logic [MEM_TAG_WIDTH-1:0] tag,
                           input int mode);
        int line;
        line = int'(addr[MEM_DEPTH_LOG2-1:0]);
        for (int b = 0; b < BEATS; b++) exp_beats[b] = model_beat(line, b);
        send_cmd(addr, tag, 1'b0, 1'b0);
        collect_resp(tag, mode, 0);
    endtask

    task automatic applyStimulus(input vec_t v);
        if (v.cmd.rw) begin
            for (int b = 0; b < BEATS; b++) wbeats[b] = {4{v.base + 32'(b)}};
            do_write(v.cmd.addr, v.cmd.tag);
        end else begin
            for (int b = 0; b < BEATS; b++) exp_beats[b] = v.exp_zero ? '0 : {4{v.exp_base + 32'(b)}};
            send_cmd(v.cmd.addr, v.cmd.tag, 1'b0, 1'b0);
            collect_resp(v.cmd.tag, v.mode, 0);
        end
    endtask

    initial begin
        int pool [8];
        int d0;
        int line;
        logic [MEM_ADDR_WIDTH-1:0] raddr;

        pool = '{'h010, 'h022, 'h3FF, 'h000, 'h155, 'h2AA, 'h0F0, 'h301};

        vecs[0] = mk(1'b1, 26'h010, 5'd3,  32'hA0,       0, 1'b0, 32'h0);
        vecs[1] = mk(1'b0, 26'h010, 5'd7,  32'h0,        0, 1'b0, 32'hA0);
        vecs[2] = mk(1'b0, 26'h022, 5'd1,  32'h0,        0, 1'b1, 32'h0);
        vecs[3] = mk(1'b1, 26'h022, 5'd2,  32'h5500,     0, 1'b0, 32'h0);
        vecs[4] = mk(1'b0, 26'h422, 5'd1,  32'h0,        0, 1'b0, 32'h5500);
        vecs[5] = mk(1'b0, 26'h010, 5'd9,  32'h0,        1, 1'b0, 32'hA0);
        vecs[6] = mk(1'b1, 26'h3FF, 5'd31, 32'h12340000, 0, 1'b0, 32'h0);
        vecs[7] = mk(1'b0, 26'h3FF, 5'd30, 32'h0,        2, 1'b0, 32'h12340000);
        vecs[8] = mk(1'b0, 26'h7FF, 5'd0,  32'h0,        1, 1'b0, 32'h12340000);

        reset          = 1'b1;
        mem_cmd_valid  = 1'b0;
        mem_cmd_addr   = '0;
        mem_cmd_tag    = '0;
        mem_cmd_rw     = 1'b0;
        mem_data_valid = 1'b0;
        mem_data_data  = '0;
        mem_resp_ready = 1'b0;

        $display("[TB] reset");
        tick();
        tick();
        checkResetValues("reset");
        reset = 1'b0;
        tick();
        checkOutput("cmd_ready_first_idle", DW'(mem_cmd_ready), DW'(1'b1));

        $display("[TB] directed table");
        for (int i = 0; i < NVEC; i++) applyStimulus(vecs[i]);

        $display("[TB] data beat in IDLE and command during RD_WAIT");
        checkOutput("proto_err_clear", DW'(proto_err), DW'(1'b0));
        d0 = data_hs_cnt;
        mem_data_valid = 1'b1;
        mem_data_data  = {4{32'hDEADBEEF}};
        tick();
        mem_data_valid = 1'b0;
        checkOutput("proto_err_set", DW'(proto_err), DW'(1'b1));
        checkOutput("stray_beat_not_taken", DW'(data_hs_cnt - d0), '0);
        for (int b = 0; b < BEATS; b++) exp_beats[b] = model_beat('h010, b);
        send_cmd(26'h010, 5'd4, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            checkOutput("cmd_ready_busy", DW'(mem_cmd_ready), DW'(1'b0));
            tick();
        end
        mem_cmd_valid = 1'b0;
        collect_resp(5'd4, 0, 4);
        checkOutput("proto_err_sticky", DW'(proto_err), DW'(1'b1));

        $display("[TB] randomized traffic");
        for (int i = 0; i < 40; i++) begin
            line  = pool[$urandom_range(0, 7)];
            raddr = {16'($urandom_range(0, 65535)), 10'(line)};
            if ($urandom_range(0, 1) == 1) begin
                for (int b = 0; b < BEATS; b++) wbeats[b] = {$urandom(), $urandom(), $urandom(), $urandom()};
                do_write(raddr, 5'($urandom_range(0, 31)));
            end else begin
                do_read(raddr, 5'($urandom_range(0, 31)), int'($urandom_range(0, 2)));
            end
        end

        $display("[TB] reset in the middle of a write");
        for (int b = 0; b < BEATS; b++) wbeats[b] = {$urandom(), $urandom(), $urandom(), $urandom()};
        send_cmd(26'h040, 5'd5, 1'b1, 1'b0);
        send_data(2);
        reset = 1'b1;
        #1;
        checkResetValues("midwrite_reset");
        tick();
        tick();
        reset = 1'b0;
        model_written.delete();
        tick();
        checkOutput("cmd_ready_after_reset", DW'(mem_cmd_ready), DW'(1'b1));
        do_read(26'h040, 5'd6, 0);
        do_read(26'h010, 5'd8, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
        $finish;
    end

endmodule
